mpu_frame_rx: RTL and testbench

- Return-path companion to the MPU command sequencer. The sequencer launches a 14-byte burst read from register 0x3B.
- This block consumes the byte stream the I2C master delivers for that burst. It assembles the stream into seven signed 16-bit sensor words: accel X/Y/Z, temperature, gyro X/Y/Z.
- It publishes all seven words atomically with a one-cycle valid strobe, and detects short, long, NACKed and stalled frames.

---
 rtl/mpu_frame_rx.sv | 191 +++++++++++++++++++
 tb/tb_mpu_frame_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_frame_rx.sv
// Receive-side assembler for the MPU 14-byte burst read starting at 0x3B.
// It collects bytes into a shadow buffer and publishes all seven sensor words atomically on xfer_done.
module mpu_frame_rx #(
    parameter int unsigned NBYTES  = 14,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_xfer_done,
    input  logic        i_xfer_err,
    output logic [15:0] o_accel_x,
    output logic [15:0] o_accel_y,
    output logic [15:0] o_accel_z,
    output logic [15:0] o_temp,
    output logic [15:0] o_gyro_x,
    output logic [15:0] o_gyro_y,
    output logic [15:0] o_gyro_z,
    output logic        o_frame_valid,
    output logic        o_frame_err,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam int unsigned IW     = $clog2(NBYTES + 1);
    localparam int unsigned NWORDS = 7;
    localparam int unsigned TW     = 17;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [7:0]      r_shadow     [NBYTES];
    logic [7:0]      w_shadow_nxt [NBYTES];
    logic [15:0]     r_word       [NWORDS];
    logic            r_frame_valid;
    logic            r_frame_err;
    logic [15:0]     r_frame_cnt;
    logic [7:0]      r_err_cnt;

    logic            w_accept;
    logic            w_commit;
    logic            w_error;
    logic            w_restart;
    logic            w_timeout;
    logic            w_last_byte;

    assign w_timeout   = (r_timer == TW'(TIMEOUT));
    assign w_last_byte = i_rx_valid && (r_idx == IW'(NBYTES - 1));

    // Priority inside a frame: restart > bus error > byte/done handling > timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_error     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame_start) begin
                    w_restart = 1'b1;
                end
            end
            S_COLLECT: begin
                if (i_frame_start) begin
                    w_restart = 1'b1;
                end else if (i_xfer_err) begin
                    w_error = 1'b1;
                end else begin
                    if (i_rx_valid) begin
                        w_accept  = 1'b1;
                        w_idx_nxt = r_idx + IW'(1);
                    end
                    if (i_xfer_done) begin
                        if (w_last_byte) begin
                            w_commit = 1'b1;
                        end else begin
                            w_error = 1'b1;
                        end
                    end else if (w_last_byte) begin
                        w_state_nxt = S_WAIT_DONE;
                    end else if (!i_rx_valid && w_timeout) begin
                        w_error = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (i_frame_start) begin
                    w_restart = 1'b1;
                end else if (i_xfer_err || i_rx_valid) begin
                    w_error = 1'b1;
                end else if (i_xfer_done) begin
                    w_commit = 1'b1;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_commit || w_error) begin
            w_state_nxt = S_IDLE;
        end
        if (w_restart) begin
            w_state_nxt = S_COLLECT;
            w_idx_nxt   = '0;
        end
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_accept) begin
            w_shadow_nxt[r_idx] = i_rx_data;
        end
    end

    always_comb begin
        w_timer_nxt = '0;
        if (!w_restart && !w_accept && (w_state_nxt != S_IDLE)) begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_timer       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_cnt     <= '0;
            for (int unsigned i = 0; i < NBYTES; i++) begin
                r_shadow[i] <= '0;
            end
            for (int unsigned k = 0; k < NWORDS; k++) begin
                r_word[k] <= '0;
            end
        end else begin
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_commit;
            r_frame_err   <= w_error;
            // Commit reads the next-shadow view so a final byte arriving with xfer_done is included.
            if (w_commit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                for (int unsigned k = 0; k < NWORDS; k++) begin
                    r_word[k] <= {w_shadow_nxt[2*k], w_shadow_nxt[2*k+1]};
                end
            end
            if (w_error && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_accel_x     = r_word[0];
    assign o_accel_y     = r_word[1];
    assign o_accel_z     = r_word[2];
    assign o_temp        = r_word[3];
    assign o_gyro_x      = r_word[4];
    assign o_gyro_y      = r_word[5];
    assign o_gyro_z      = r_word[6];
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_cnt   = r_frame_cnt;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_mpu_frame_rx.sv
// Directed self-checking bench for mpu_frame_rx, built with a short timeout so stalls stay fast.
module tb_mpu_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        xfer_done;
    logic        xfer_err;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_fcnt = 0;
    int exp_ecnt = 0;

    mpu_frame_rx #(.NBYTES(14), .TIMEOUT(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(frame_start),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .i_xfer_done  (xfer_done),
        .i_xfer_err   (xfer_err),
        .o_accel_x    (accel_x),
        .o_accel_y    (accel_y),
        .o_accel_z    (accel_z),
        .o_temp       (temp),
        .o_gyro_x     (gyro_x),
        .o_gyro_y     (gyro_y),
        .o_gyro_z     (gyro_z),
        .o_frame_valid(frame_valid),
        .o_frame_err  (frame_err),
        .o_busy       (busy),
        .o_frame_cnt  (frame_cnt),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [111:0] seq_words(input logic [7:0] base);
        logic [111:0] v;
        for (int i = 0; i < 14; i++) begin
            v[111 - 8*i -: 8] = base + 8'(i);
        end
        return v;
    endfunction

    function automatic logic [111:0] all_words();
        return {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(base + 8'(i));
        end
    endtask

    task automatic send_done();
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 0; rx_valid = 0; rx_data = 0; xfer_done = 0; xfer_err = 0;
        cyc(); cyc();
        checks++;
        if ({all_words(), frame_valid, frame_err, busy, frame_cnt, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: got words=%h fv=%b fe=%b busy=%b fc=%h ec=%h expected all zero",
                     all_words(), frame_valid, frame_err, busy, frame_cnt, err_cnt);
        end
        rst = 1'b0;
        cyc();
        rx_valid = 1'b1; rx_data = 8'hAA; xfer_done = 1'b1; xfer_err = 1'b1;
        cyc();
        rx_valid = 1'b0; xfer_done = 1'b0; xfer_err = 1'b0;
        checks++;
        if ({frame_valid, frame_err, busy, err_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL idle_ignore: got fv=%b fe=%b busy=%b ec=%h expected 0 0 0 00",
                     frame_valid, frame_err, busy, err_cnt);
        end
    endtask

    task automatic test_good_frame();
        send_start();
        send_bytes(8'h01, 14);
        checks++;
        if (busy !== 1'b1 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_busy: got busy=%b fv=%b expected busy=1 fv=0", busy, frame_valid);
        end
        send_done();
        exp_fcnt++;
        checks++;
        if (all_words() !== 112'h0102_0304_0506_0708_090A_0B0C_0D0E) begin
            failures++;
            $display("FAIL good_words: got %h expected 0102030405060708090a0b0c0d0e", all_words());
        end
        checks++;
        if (frame_valid !== 1'b1 || frame_err !== 1'b0 || frame_cnt !== 16'(exp_fcnt) || err_cnt !== 8'(exp_ecnt)) begin
            failures++;
            $display("FAIL good_flags: got fv=%b fe=%b fc=%0d ec=%0d expected 1 0 %0d %0d",
                     frame_valid, frame_err, frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL good_pulse: got fv=%b busy=%b expected 0 0", frame_valid, busy);
        end
    endtask

    task automatic test_sign_hold();
        send_start();
        send_byte(8'hFF);
        send_byte(8'h38);
        send_bytes(8'h03, 12);
        send_done();
        exp_fcnt++;
        checks++;
        if (accel_x !== 16'hFF38 || $signed(accel_x) != -200 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL sign_word: got accel_x=%h fv=%b expected ff38 (-200) fv=1", accel_x, frame_valid);
        end
        cyc();
        send_start();
        send_bytes(8'h77, 5);
        send_done();
        exp_ecnt++;
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0 || err_cnt !== 8'(exp_ecnt) || accel_x !== 16'hFF38 ||
            frame_cnt !== 16'(exp_fcnt)) begin
            failures++;
            $display("FAIL short_frame: got fe=%b fv=%b ec=%0d accel_x=%h fc=%0d expected 1 0 %0d ff38 %0d",
                     frame_err, frame_valid, err_cnt, accel_x, frame_cnt, exp_ecnt, exp_fcnt);
        end
        cyc();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: got fe=%b expected 0", frame_err);
        end
    endtask

    task automatic test_boundary();
        send_start();
        send_bytes(8'h20, 13);
        rx_valid = 1'b1; rx_data = 8'h2D; xfer_done = 1'b1;
        cyc();
        rx_valid = 1'b0; xfer_done = 1'b0;
        exp_fcnt++;
        checks++;
        if (frame_valid !== 1'b1 || all_words() !== seq_words(8'h20) || frame_cnt !== 16'(exp_fcnt)) begin
            failures++;
            $display("FAIL last_byte_with_done: got fv=%b words=%h fc=%0d expected 1 %h %0d",
                     frame_valid, all_words(), frame_cnt, seq_words(8'h20), exp_fcnt);
        end
        cyc();
        send_start();
        send_bytes(8'h40, 15);
        exp_ecnt++;
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0 || err_cnt !== 8'(exp_ecnt) || all_words() !== seq_words(8'h20)) begin
            failures++;
            $display("FAIL long_frame: got fe=%b fv=%b ec=%0d words=%h expected 1 0 %0d %h",
                     frame_err, frame_valid, err_cnt, all_words(), exp_ecnt, seq_words(8'h20));
        end
        cyc();
    endtask

    task automatic test_nack();
        send_start();
        send_bytes(8'h60, 3);
        xfer_err = 1'b1;
        cyc();
        xfer_err = 1'b0;
        exp_ecnt++;
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'(exp_ecnt)) begin
            failures++;
            $display("FAIL nack_collect: got fe=%b busy=%b ec=%0d expected 1 0 %0d", frame_err, busy, err_cnt, exp_ecnt);
        end
        cyc();
        send_start();
        send_bytes(8'h70, 14);
        xfer_err = 1'b1; xfer_done = 1'b1;
        cyc();
        xfer_err = 1'b0; xfer_done = 1'b0;
        exp_ecnt++;
        checks++;
        if (frame_err !== 1'b1 || frame_valid !== 1'b0 || err_cnt !== 8'(exp_ecnt) ||
            frame_cnt !== 16'(exp_fcnt) || all_words() !== seq_words(8'h20)) begin
            failures++;
            $display("FAIL err_beats_done: got fe=%b fv=%b ec=%0d fc=%0d words=%h expected 1 0 %0d %0d %h",
                     frame_err, frame_valid, err_cnt, frame_cnt, all_words(), exp_ecnt, exp_fcnt, seq_words(8'h20));
        end
        cyc();
    endtask

    task automatic test_timeout_restart();
        int n;
        send_start();
        send_bytes(8'h80, 6);
        n = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            cyc();
            if (frame_err === 1'b1) n = i;
        end
        exp_ecnt++;
        checks++;
        if (n != 101 || busy !== 1'b0 || err_cnt !== 8'(exp_ecnt)) begin
            failures++;
            $display("FAIL timeout: got err after %0d cycles busy=%b ec=%0d expected 101 0 %0d", n, busy, err_cnt, exp_ecnt);
        end
        cyc();
        send_start();
        send_bytes(8'h50, 9);
        frame_start = 1'b1; xfer_done = 1'b1;
        cyc();
        frame_start = 1'b0; xfer_done = 1'b0;
        checks++;
        if (frame_err !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_silent: got fe=%b fv=%b busy=%b expected 0 0 1", frame_err, frame_valid, busy);
        end
        send_bytes(8'h10, 14);
        send_done();
        exp_fcnt++;
        checks++;
        if (frame_valid !== 1'b1 || all_words() !== seq_words(8'h10) || err_cnt !== 8'(exp_ecnt) ||
            frame_cnt !== 16'(exp_fcnt)) begin
            failures++;
            $display("FAIL restart_frame: got fv=%b words=%h ec=%0d fc=%0d expected 1 %h %0d %0d",
                     frame_valid, all_words(), err_cnt, frame_cnt, seq_words(8'h10), exp_ecnt, exp_fcnt);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        send_start();
        send_bytes(8'h90, 4);
        rst = 1'b1;
        #1;
        checks++;
        if ({all_words(), frame_valid, frame_err, busy, frame_cnt, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got words=%h busy=%b fc=%h ec=%h expected all zero",
                     all_words(), busy, frame_cnt, err_cnt);
        end
        cyc();
        rst = 1'b0;
        exp_fcnt = 0;
        exp_ecnt = 0;
        cyc();
        send_bytes(8'hA0, 10);
        send_done();
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || accel_x !== 16'h0000 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_idle: got fv=%b fe=%b accel_x=%h fc=%0d expected 0 0 0000 0",
                     frame_valid, frame_err, accel_x, frame_cnt);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            send_start();
            send_done();
        end
        cyc();
        checks++;
        if (err_cnt !== 8'hFF || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL err_saturate: got ec=%h fc=%0d expected ff 0", err_cnt, frame_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        cyc();
        send_start();
        send_bytes(8'hC0, 14);
        send_done();
        checks++;
        if (frame_valid !== 1'b1 || frame_cnt !== 16'h0000 || err_cnt !== 8'hFF || all_words() !== seq_words(8'hC0)) begin
            failures++;
            $display("FAIL cnt_wrap: got fv=%b fc=%h ec=%h words=%h expected 1 0000 ff %h",
                     frame_valid, frame_cnt, err_cnt, all_words(), seq_words(8'hC0));
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_sign_hold();
        test_boundary();
        test_nack();
        test_timeout_restart();
        test_reset_mid();
        test_err_saturate();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
